// File: rtl/pps_capture.sv
// PPS edge timestamper: synchronises and qualifies pps_in, latches a latency-compensated
// timestamp with its edge-to-edge period, tracks lock and offers records over valid/ready.
module pps_capture #(
    parameter int              TS_W           = 64,
    parameter int              MIN_HIGH       = 4,
    parameter logic [TS_W-1:0] LAT_COMP_VAL   = 60,
    parameter logic [TS_W-1:0] NOMINAL_PERIOD = 1_000_000_000,
    parameter logic [TS_W-1:0] TOLERANCE      = 1_000,
    parameter int              MISS_CNT_W     = 16
) (
    input  logic                  clk_pps,
    input  logic                  reset_pps,
    input  logic                  pps_in,
    input  logic [TS_W-1:0]       timestamp,
    input  logic                  clr_status,
    input  logic                  ts_ready,
    output logic                  ts_valid,
    output logic [TS_W-1:0]       ts_data,
    output logic [TS_W-1:0]       ts_period,
    output logic                  ts_period_ok,
    output logic                  locked,
    output logic                  overrun,
    output logic [MISS_CNT_W-1:0] miss_cnt,
    output logic [1:0]            dbg_state
);

    localparam int HC_W = $clog2(MIN_HIGH + 1);
    localparam logic [TS_W-1:0]       WIN_LO   = NOMINAL_PERIOD - TOLERANCE;
    localparam logic [TS_W-1:0]       WIN_HI   = NOMINAL_PERIOD + TOLERANCE;
    localparam logic [TS_W-1:0]       TO_LIMIT = NOMINAL_PERIOD + TOLERANCE + LAT_COMP_VAL;
    localparam logic [MISS_CNT_W-1:0] MISS_MAX = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_s1;
    logic            r_s2;
    logic [1:0]      r_sync_vld;
    logic [HC_W-1:0] r_hi_cnt;
    logic            r_armed;
    logic [TS_W-1:0] r_prev_ts;
    logic            r_have_prev;

    logic            w_ev;
    logic [TS_W-1:0] w_cap;
    logic [TS_W-1:0] w_per;
    logic [TS_W-1:0] w_since;
    logic            w_in_win;
    logic            w_first;
    logic            w_timeout;
    logic            w_load;
    logic            w_drop;
    logic            w_miss_inc;

    // r_sync_vld marks when r_s2 holds a real pps sample, so a pulse already
    // high out of reset cannot arm the detector through the reset-zeroed flops.
    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_sync_vld <= 2'b00;
            r_hi_cnt   <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_s1       <= pps_in;
            r_s2       <= r_s1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (!r_s2)
                r_hi_cnt <= '0;
            else if (r_hi_cnt != HC_W'(MIN_HIGH))
                r_hi_cnt <= r_hi_cnt + HC_W'(1);
            if (!r_s2 && r_sync_vld[1])
                r_armed <= 1'b1;
            else if (w_ev)
                r_armed <= 1'b0;
        end
    end

    assign w_ev       = r_armed & r_s2 & (r_hi_cnt == HC_W'(MIN_HIGH - 1));
    assign w_cap      = timestamp - LAT_COMP_VAL;
    assign w_per      = w_cap - r_prev_ts;
    assign w_since    = timestamp - r_prev_ts;
    assign w_in_win   = r_have_prev & (w_per >= WIN_LO) & (w_per <= WIN_HI);
    assign w_first    = (r_state == ST_UNLOCKED) | ~r_have_prev;
    assign w_timeout  = (r_state != ST_UNLOCKED) & ~w_ev & (w_since > TO_LIMIT);
    assign w_miss_inc = w_timeout & (r_state == ST_LOCKED);

    // Handshake: a record transfers on any cycle with ts_valid & ts_ready; while
    // ts_valid & ~ts_ready the record is frozen and a new edge is dropped (overrun).
    assign w_load = w_ev & (~ts_valid | ts_ready);
    assign w_drop = w_ev & ts_valid & ~ts_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_ev)
                    w_state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE, ST_LOCKED: begin
                if (w_ev)
                    w_state_nxt = w_in_win ? ST_LOCKED : ST_ACQUIRE;
                else if (w_timeout)
                    w_state_nxt = ST_UNLOCKED;
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_pps) begin
        if (reset_pps)
            r_state <= ST_UNLOCKED;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            ts_valid     <= 1'b0;
            ts_data      <= '0;
            ts_period    <= '0;
            ts_period_ok <= 1'b0;
            overrun      <= 1'b0;
            miss_cnt     <= '0;
            r_prev_ts    <= '0;
            r_have_prev  <= 1'b0;
        end else begin
            if (w_load) begin
                ts_valid     <= 1'b1;
                ts_data      <= w_cap;
                ts_period    <= w_first ? '0 : w_per;
                ts_period_ok <= ~w_first & w_in_win;
            end else if (ts_ready) begin
                ts_valid <= 1'b0;
            end

            // Dropped edges still advance the period reference.
            if (w_ev) begin
                r_prev_ts   <= w_cap;
                r_have_prev <= 1'b1;
            end else if (w_miss_inc) begin
                r_have_prev <= 1'b0;
            end

            if (w_drop)
                overrun <= 1'b1;
            else if (clr_status)
                overrun <= 1'b0;

            if (w_miss_inc)
                miss_cnt <= clr_status ? MISS_CNT_W'(1)
                          : (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + MISS_CNT_W'(1);
            else if (clr_status)
                miss_cnt <= '0;
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pps_capture.sv
// Directed bench for pps_capture: a per-cycle reference model compared on every falling
// edge, plus hand-computed checks of key records, lock transitions and status counters.
module tb_pps_capture;

    localparam int          TS_W     = 64;
    localparam int          MIN_HIGH = 4;
    localparam int          MISS_W   = 16;
    localparam logic [63:0] NOM      = 64'd1_000_000_000;
    localparam logic [63:0] TOL      = 64'd1_000;
    localparam logic [63:0] LAT      = 64'd60;

    logic              clk_pps = 1'b0;
    logic              reset_pps;
    logic              pps_in;
    logic [TS_W-1:0]   timestamp;
    logic              clr_status;
    logic              ts_ready;
    logic              ts_valid;
    logic [TS_W-1:0]   ts_data;
    logic [TS_W-1:0]   ts_period;
    logic              ts_period_ok;
    logic              locked;
    logic              overrun;
    logic [MISS_W-1:0] miss_cnt;
    logic [1:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    pps_capture dut (
        .clk_pps      (clk_pps),
        .reset_pps    (reset_pps),
        .pps_in       (pps_in),
        .timestamp    (timestamp),
        .clr_status   (clr_status),
        .ts_ready     (ts_ready),
        .ts_valid     (ts_valid),
        .ts_data      (ts_data),
        .ts_period    (ts_period),
        .ts_period_ok (ts_period_ok),
        .locked       (locked),
        .overrun      (overrun),
        .miss_cnt     (miss_cnt),
        .dbg_state    (dbg_state)
    );

    always #5 clk_pps = ~clk_pps;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge = MIN_HIGH consecutive high pps samples after a low one,
    // seen through two sync stages; states 0 unlocked, 1 acquire, 2 locked.
    bit          m_started = 1'b0;
    logic [15:0] m_hist    = '0;
    int          m_n       = 0;
    int          m_st      = 0;
    logic [63:0] m_prev    = '0;
    bit          m_havep   = 1'b0;
    bit          e_valid   = 1'b0;
    logic [63:0] e_data    = '0;
    logic [63:0] e_per     = '0;
    bit          e_ok      = 1'b0;
    bit          e_ovr     = 1'b0;
    int          e_miss    = 0;

    always @(negedge clk_pps) begin : model_blk
        bit          ev, to, first, inwin, allhi, load, drop;
        logic [63:0] cap_v, per_v;
        if (m_started) begin
            cmp("m_valid", ts_valid, e_valid);
            cmp("m_locked", locked, m_st == 2);
            cmp("m_state", 64'(dbg_state), 64'(m_st));
            cmp("m_overrun", overrun, e_ovr);
            cmp("m_miss", miss_cnt, 64'(e_miss));
            if (e_valid) begin
                cmp("m_data", ts_data, e_data);
                cmp("m_period", ts_period, e_per);
                cmp("m_ok", ts_period_ok, e_ok);
            end
        end
        if (reset_pps) begin
            m_started = 1'b1;
            m_hist = '0; m_n = 0; m_st = 0; m_prev = '0; m_havep = 1'b0;
            e_valid = 1'b0; e_data = '0; e_per = '0; e_ok = 1'b0; e_ovr = 1'b0; e_miss = 0;
        end else begin
            allhi = 1'b1;
            for (int k = 1; k <= MIN_HIGH; k++)
                if (!m_hist[k]) allhi = 1'b0;
            ev    = (m_n >= MIN_HIGH + 2) && allhi && !m_hist[MIN_HIGH+1];
            to    = (m_st != 0) && !ev && ((timestamp - m_prev) > (NOM + TOL + LAT));
            load  = ev && (!e_valid || ts_ready);
            drop  = ev && e_valid && !ts_ready;
            cap_v = timestamp - LAT;
            per_v = cap_v - m_prev;
            first = (m_st == 0) || !m_havep;
            inwin = m_havep && (per_v >= NOM - TOL) && (per_v <= NOM + TOL);
            if (load) begin
                e_valid = 1'b1; e_data = cap_v;
                e_per = first ? 64'd0 : per_v;
                e_ok = !first && inwin;
            end else if (ts_ready) begin
                e_valid = 1'b0;
            end
            if (drop) e_ovr = 1'b1;
            else if (clr_status) e_ovr = 1'b0;
            if (to && m_st == 2) begin
                e_miss = clr_status ? 1 : (e_miss == 65535 ? 65535 : e_miss + 1);
                m_havep = 1'b0;
            end else if (clr_status) begin
                e_miss = 0;
            end
            if (ev) begin
                m_st = (m_st == 0) ? 1 : (inwin ? 2 : 1);
                m_prev = cap_v;
                m_havep = 1'b1;
            end else if (to) begin
                m_st = 0;
            end
            m_hist = {m_hist[14:0], pps_in};
            if (m_n < 1000) m_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_pps);
            #1;
            timestamp  = timestamp + 64'd10;
            clr_status = 1'b0;
        end
    endtask

    // Rise timed so the captured (compensated) value equals cap; returns in the
    // first cycle the resulting record is visible.
    task automatic pulse_at(input logic [63:0] cap);
        tick(1);
        timestamp = cap + 64'd10;
        pps_in = 1'b1;
        tick(6);
        pps_in = 1'b0;
    endtask

    initial begin : stim
        int          cnt;
        logic [63:0] wrap_cap;
        reset_pps = 1'b1; pps_in = 1'b1; clr_status = 1'b0; ts_ready = 1'b1; timestamp = '0;
        tick(3);
        reset_pps = 1'b0;
        tick(10);
        cmp("high_thru_reset_no_rec", ts_valid, 0);
        pps_in = 1'b0;
        tick(5);
        cmp("rst_valid", ts_valid, 0);
        cmp("rst_locked", locked, 0);
        cmp("rst_overrun", overrun, 0);
        cmp("rst_miss", miss_cnt, 0);
        cmp("rst_data", ts_data, 0);
        cmp("rst_period", ts_period, 0);
        cmp("rst_ok", ts_period_ok, 0);

        // Too-short pulse is filtered.
        tick(1); pps_in = 1'b1; tick(3); pps_in = 1'b0; tick(8);
        cmp("short_no_rec", ts_valid, 0);
        cmp("short_state", dbg_state, 0);

        // First edge, held high: exactly one record.
        tick(1); timestamp = 64'd1010; pps_in = 1'b1; tick(6);
        cmp("e1_valid", ts_valid, 1);
        cmp("e1_data", ts_data, 64'd1000);
        cmp("e1_period", ts_period, 0);
        cmp("e1_ok", ts_period_ok, 0);
        cmp("e1_state", dbg_state, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ts_valid) cnt++;
        end
        cmp("e1_single_record", cnt, 0);
        pps_in = 1'b0; tick(3);

        pulse_at(64'd1_000_001_000);
        cmp("e2_period", ts_period, 64'd1_000_000_000);
        cmp("e2_ok", ts_period_ok, 1);
        cmp("e2_locked", locked, 1);
        tick(3);
        pulse_at(64'd1_999_999_000);
        cmp("e3_period", ts_period, 64'd999_998_000);
        cmp("e3_ok", ts_period_ok, 0);
        cmp("e3_state", dbg_state, 1);
        tick(3);
        pulse_at(64'd2_999_999_000);
        cmp("e4_locked", locked, 1);

        // Missing pulse: timeout once delta exceeds 1e9+1060.
        tick(2); timestamp = 64'd4_000_000_030; tick(3);
        cmp("to_edge_still_locked", locked, 1);
        tick(2);
        cmp("to_locked", locked, 0);
        cmp("to_miss", miss_cnt, 1);

        // Relock, then timeout coinciding with clr_status.
        tick(2);
        pulse_at(64'd5_000_000_000);
        cmp("re_first_period", ts_period, 0);
        cmp("re_first_state", dbg_state, 1);
        tick(3);
        pulse_at(64'd6_000_000_000);
        cmp("re_locked", locked, 1);
        tick(2); timestamp = 64'd7_000_001_050; tick(2);
        clr_status = 1'b1;
        tick(1);
        cmp("clr_to_miss", miss_cnt, 1);
        cmp("clr_to_locked", locked, 0);

        // Consumer stalls across two edges.
        ts_ready = 1'b0;
        tick(2);
        pulse_at(64'd8_000_000_000);
        cmp("ovr_first_valid", ts_valid, 1);
        tick(3);
        pulse_at(64'd9_000_000_000);
        cmp("ovr_held_data", ts_data, 64'd8_000_000_000);
        cmp("ovr_held_period", ts_period, 0);
        cmp("ovr_flag", overrun, 1);
        cmp("ovr_locked", locked, 1);
        ts_ready = 1'b1; tick(1);
        cmp("ovr_drained", ts_valid, 0);
        clr_status = 1'b1; tick(1);
        cmp("ovr_cleared", overrun, 0);
        cmp("miss_cleared", miss_cnt, 0);

        // Timestamp wraps through 2^64.
        wrap_cap = 64'd0 - 64'd500_000_000;
        tick(2);
        pulse_at(wrap_cap);
        cmp("wrap_a_period", ts_period, 0);
        cmp("wrap_a_miss", miss_cnt, 1);
        tick(3);
        pulse_at(64'd500_000_000);
        cmp("wrap_b_data", ts_data, 64'd500_000_000);
        cmp("wrap_b_period", ts_period, 64'd1_000_000_000);
        cmp("wrap_b_ok", ts_period_ok, 1);

        // Reset while a record is pending.
        ts_ready = 1'b0;
        tick(2);
        pulse_at(64'd1_500_000_000);
        cmp("mid_pending", ts_valid, 1);
        reset_pps = 1'b1; tick(1); reset_pps = 1'b0;
        cmp("mid_rst_valid", ts_valid, 0);
        cmp("mid_rst_locked", locked, 0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
